// File: rtl/id_stage.sv
// RV32I instruction decode stage.
// Decodes the IF/ID instruction, reads the 32x32 register file with a
// write-back bypass, builds the sign-extended immediate and registers the
// result into the ID/EX pipeline register. Load-use hazards insert a bubble
// and stall IF for one cycle.
module id_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [31:0]     id_inst_i,
    input  logic            id_ready_i,
    input  logic            ex_stall_i,
    input  logic            flush_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_dat_i,
    output logic            id_stall_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rs1_dat_o,
    output logic [XLEN-1:0] ex_rs2_dat_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [4:0]      ex_rs1_o,
    output logic [4:0]      ex_rs2_o,
    output logic [4:0]      ex_rd_o,
    output logic [3:0]      ex_alu_op_o,
    output logic            ex_alu_src_o,
    output logic            ex_mem_rd_o,
    output logic            ex_mem_wr_o,
    output logic [2:0]      ex_mem_size_o,
    output logic            ex_reg_we_o,
    output logic            ex_branch_o,
    output logic            ex_jump_o,
    output logic            ex_illegal_o
);

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // ALU op from funct3/funct7[5]; SUB exists only for register-register ops.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                   input logic       f7b5,
                                                   input logic       is_reg_op);
        logic [3:0] op;
        case (f3)
            3'd0:    op = (is_reg_op && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = f7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            3'd7:    op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Instruction fields
    logic [6:0] opcode_s;
    logic [4:0] rd_idx_s;
    logic [4:0] rs1_idx_s;
    logic [4:0] rs2_idx_s;
    logic [2:0] funct3_s;
    logic       funct7b5_s;

    assign opcode_s   = id_inst_i[6:0];
    assign rd_idx_s   = id_inst_i[11:7];
    assign funct3_s   = id_inst_i[14:12];
    assign rs1_idx_s  = id_inst_i[19:15];
    assign rs2_idx_s  = id_inst_i[24:20];
    assign funct7b5_s = id_inst_i[30];

    // Register file storage; x0 is never written so it stays zero.
    logic [XLEN-1:0] rf_r [0:31];
    logic            wb_hit_s;

    assign wb_hit_s = wb_we_i && (wb_rd_i != 5'd0);

    // Register file write port; write-back is independent of flush and stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= '0;
            end
        end else if (wb_hit_s) begin
            rf_r[wb_rd_i] <= wb_dat_i;
        end else begin
            rf_r[0] <= '0;
        end
    end

    // Register file read ports with same-cycle write-back bypass.
    logic [XLEN-1:0] rs1_dat_s;
    logic [XLEN-1:0] rs2_dat_s;

    // Operand read: x0 forced to zero, bypass before array read.
    always_comb begin
        rs1_dat_s = '0;
        rs2_dat_s = '0;
        if (rs1_idx_s == 5'd0) begin
            rs1_dat_s = '0;
        end else if (wb_hit_s && (wb_rd_i == rs1_idx_s)) begin
            rs1_dat_s = wb_dat_i;
        end else begin
            rs1_dat_s = rf_r[rs1_idx_s];
        end
        if (rs2_idx_s == 5'd0) begin
            rs2_dat_s = '0;
        end else if (wb_hit_s && (wb_rd_i == rs2_idx_s)) begin
            rs2_dat_s = wb_dat_i;
        end else begin
            rs2_dat_s = rf_r[rs2_idx_s];
        end
    end

    // Decode results
    logic [3:0]      dec_alu_op_s;
    logic            dec_alu_src_s;
    logic            dec_mem_rd_s;
    logic            dec_mem_wr_s;
    logic [2:0]      dec_mem_size_s;
    logic            dec_reg_we_s;
    logic            dec_branch_s;
    logic            dec_jump_s;
    logic            dec_illegal_s;
    logic            use_rs1_s;
    logic            use_rs2_s;
    logic [XLEN-1:0] dec_imm_s;

    // Opcode decode and immediate selection.
    always_comb begin
        dec_alu_op_s   = ALU_ADD;
        dec_alu_src_s  = 1'b0;
        dec_mem_rd_s   = 1'b0;
        dec_mem_wr_s   = 1'b0;
        dec_mem_size_s = 3'd0;
        dec_reg_we_s   = 1'b0;
        dec_branch_s   = 1'b0;
        dec_jump_s     = 1'b0;
        dec_illegal_s  = 1'b0;
        use_rs1_s      = 1'b1;
        use_rs2_s      = 1'b0;
        dec_imm_s      = '0;
        case (opcode_s)
            OPC_OP: begin
                dec_alu_op_s = alu_from_funct(funct3_s, funct7b5_s, 1'b1);
                dec_reg_we_s = 1'b1;
                use_rs2_s    = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_alu_op_s  = alu_from_funct(funct3_s, funct7b5_s, 1'b0);
                dec_alu_src_s = 1'b1;
                dec_reg_we_s  = 1'b1;
                dec_imm_s     = {{(XLEN-12){id_inst_i[31]}}, id_inst_i[31:20]};
            end
            OPC_LOAD: begin
                dec_alu_src_s  = 1'b1;
                dec_mem_rd_s   = 1'b1;
                dec_mem_size_s = funct3_s;
                dec_reg_we_s   = 1'b1;
                dec_imm_s      = {{(XLEN-12){id_inst_i[31]}}, id_inst_i[31:20]};
            end
            OPC_STORE: begin
                dec_alu_src_s  = 1'b1;
                dec_mem_wr_s   = 1'b1;
                dec_mem_size_s = funct3_s;
                use_rs2_s      = 1'b1;
                dec_imm_s      = {{(XLEN-12){id_inst_i[31]}}, id_inst_i[31:25], id_inst_i[11:7]};
            end
            OPC_LUI: begin
                dec_alu_op_s  = ALU_PASSB;
                dec_alu_src_s = 1'b1;
                dec_reg_we_s  = 1'b1;
                use_rs1_s     = 1'b0;
                dec_imm_s     = {{(XLEN-32){id_inst_i[31]}}, id_inst_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec_alu_src_s = 1'b1;
                dec_reg_we_s  = 1'b1;
                use_rs1_s     = 1'b0;
                dec_imm_s     = {{(XLEN-32){id_inst_i[31]}}, id_inst_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec_alu_src_s = 1'b1;
                dec_reg_we_s  = 1'b1;
                dec_jump_s    = 1'b1;
                use_rs1_s     = 1'b0;
                dec_imm_s     = {{(XLEN-20){id_inst_i[31]}}, id_inst_i[19:12],
                                 id_inst_i[20], id_inst_i[30:21], 1'b0};
            end
            OPC_JALR: begin
                dec_alu_src_s = 1'b1;
                dec_reg_we_s  = 1'b1;
                dec_jump_s    = 1'b1;
                dec_imm_s     = {{(XLEN-12){id_inst_i[31]}}, id_inst_i[31:20]};
            end
            OPC_BRANCH: begin
                dec_alu_op_s = ALU_SUB;
                dec_branch_s = 1'b1;
                use_rs2_s    = 1'b1;
                dec_imm_s    = {{(XLEN-12){id_inst_i[31]}}, id_inst_i[7],
                                id_inst_i[30:25], id_inst_i[11:8], 1'b0};
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // A destination of x0 never produces a register write.
    logic reg_we_s;
    assign reg_we_s = dec_reg_we_s && (rd_idx_s != 5'd0);

    // Load-use hazard: the load in EX produces a register that ID needs now.
    logic hazard_s;
    assign hazard_s = id_ready_i && ex_valid_o && ex_mem_rd_o && (ex_rd_o != 5'd0) &&
                      ((use_rs1_s && (rs1_idx_s == ex_rd_o)) ||
                       (use_rs2_s && (rs2_idx_s == ex_rd_o)));

    assign id_stall_o = hazard_s || ex_stall_i;

    // ID/EX register: flush beats stall, stall beats bubble, bubble beats load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= RESET_PC;
            ex_rs1_dat_o  <= '0;
            ex_rs2_dat_o  <= '0;
            ex_imm_o      <= '0;
            ex_rs1_o      <= 5'd0;
            ex_rs2_o      <= 5'd0;
            ex_rd_o       <= 5'd0;
            ex_alu_op_o   <= 4'd0;
            ex_alu_src_o  <= 1'b0;
            ex_mem_rd_o   <= 1'b0;
            ex_mem_wr_o   <= 1'b0;
            ex_mem_size_o <= 3'd0;
            ex_reg_we_o   <= 1'b0;
            ex_branch_o   <= 1'b0;
            ex_jump_o     <= 1'b0;
            ex_illegal_o  <= 1'b0;
        end else if (flush_i || (!ex_stall_i && hazard_s)) begin
            ex_valid_o    <= 1'b0;
            ex_alu_op_o   <= 4'd0;
            ex_alu_src_o  <= 1'b0;
            ex_mem_rd_o   <= 1'b0;
            ex_mem_wr_o   <= 1'b0;
            ex_mem_size_o <= 3'd0;
            ex_reg_we_o   <= 1'b0;
            ex_branch_o   <= 1'b0;
            ex_jump_o     <= 1'b0;
            ex_illegal_o  <= 1'b0;
        end else if (ex_stall_i) begin
            ex_valid_o    <= ex_valid_o;
        end else begin
            ex_valid_o    <= id_ready_i;
            ex_pc_o       <= id_pc_i;
            ex_rs1_dat_o  <= rs1_dat_s;
            ex_rs2_dat_o  <= rs2_dat_s;
            ex_imm_o      <= dec_imm_s;
            ex_rs1_o      <= rs1_idx_s;
            ex_rs2_o      <= rs2_idx_s;
            ex_rd_o       <= rd_idx_s;
            ex_alu_op_o   <= dec_alu_op_s;
            ex_alu_src_o  <= dec_alu_src_s;
            ex_mem_rd_o   <= dec_mem_rd_s;
            ex_mem_wr_o   <= dec_mem_wr_s;
            ex_mem_size_o <= dec_mem_size_s;
            ex_reg_we_o   <= reg_we_s;
            ex_branch_o   <= dec_branch_s;
            ex_jump_o     <= dec_jump_s;
            ex_illegal_o  <= dec_illegal_s;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX contents are queued when an
// instruction is driven and checked after the edge that registers it.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] id_pc_i;
    logic [31:0] id_inst_i;
    logic        id_ready_i;
    logic        ex_stall_i;
    logic        flush_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_dat_i;
    logic        id_stall_o;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o;
    logic [31:0] ex_rs1_dat_o;
    logic [31:0] ex_rs2_dat_o;
    logic [31:0] ex_imm_o;
    logic [4:0]  ex_rs1_o;
    logic [4:0]  ex_rs2_o;
    logic [4:0]  ex_rd_o;
    logic [3:0]  ex_alu_op_o;
    logic        ex_alu_src_o;
    logic        ex_mem_rd_o;
    logic        ex_mem_wr_o;
    logic [2:0]  ex_mem_size_o;
    logic        ex_reg_we_o;
    logic        ex_branch_o;
    logic        ex_jump_o;
    logic        ex_illegal_o;

    int n_cmp = 0;
    int n_bad = 0;

    id_stage dut (
        .clk(clk), .rst(rst),
        .id_pc_i(id_pc_i), .id_inst_i(id_inst_i), .id_ready_i(id_ready_i),
        .ex_stall_i(ex_stall_i), .flush_i(flush_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_dat_i(wb_dat_i),
        .id_stall_o(id_stall_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_rs1_dat_o(ex_rs1_dat_o), .ex_rs2_dat_o(ex_rs2_dat_o), .ex_imm_o(ex_imm_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
        .ex_alu_op_o(ex_alu_op_o), .ex_alu_src_o(ex_alu_src_o),
        .ex_mem_rd_o(ex_mem_rd_o), .ex_mem_wr_o(ex_mem_wr_o), .ex_mem_size_o(ex_mem_size_o),
        .ex_reg_we_o(ex_reg_we_o), .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o),
        .ex_illegal_o(ex_illegal_o)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       tag;
        bit          full;
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        src, mrd, mwr;
        logic [2:0]  sz;
        logic        we, br, jp, ill;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input string tag, input bit full, input logic valid,
                                input logic [31:0] pc, input logic [31:0] rs1d,
                                input logic [31:0] rs2d, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [3:0] op,
                                input logic src, input logic mrd, input logic mwr,
                                input logic [2:0] sz, input logic we, input logic br,
                                input logic jp, input logic ill);
        exp_t e;
        e.tag = tag; e.full = full; e.valid = valid;
        e.pc = pc; e.rs1d = rs1d; e.rs2d = rs2d; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.op = op;
        e.src = src; e.mrd = mrd; e.mwr = mwr; e.sz = sz;
        e.we = we; e.br = br; e.jp = jp; e.ill = ill;
        return e;
    endfunction

    // A killed slot: only valid and control bits are defined.
    function automatic exp_t mk_bubble(input string tag);
        return mk(tag, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
                  4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Pop the oldest expectation and compare it with the ID/EX outputs.
    task automatic check_head();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".valid"},   {31'd0, ex_valid_o},    {31'd0, e.valid});
            cmp({e.tag, ".alu_op"},  {28'd0, ex_alu_op_o},   {28'd0, e.op});
            cmp({e.tag, ".alu_src"}, {31'd0, ex_alu_src_o},  {31'd0, e.src});
            cmp({e.tag, ".mem_rd"},  {31'd0, ex_mem_rd_o},   {31'd0, e.mrd});
            cmp({e.tag, ".mem_wr"},  {31'd0, ex_mem_wr_o},   {31'd0, e.mwr});
            cmp({e.tag, ".mem_sz"},  {29'd0, ex_mem_size_o}, {29'd0, e.sz});
            cmp({e.tag, ".reg_we"},  {31'd0, ex_reg_we_o},   {31'd0, e.we});
            cmp({e.tag, ".branch"},  {31'd0, ex_branch_o},   {31'd0, e.br});
            cmp({e.tag, ".jump"},    {31'd0, ex_jump_o},     {31'd0, e.jp});
            cmp({e.tag, ".illegal"}, {31'd0, ex_illegal_o},  {31'd0, e.ill});
            if (e.full) begin
                cmp({e.tag, ".pc"},   ex_pc_o,      e.pc);
                cmp({e.tag, ".rs1d"}, ex_rs1_dat_o, e.rs1d);
                cmp({e.tag, ".rs2d"}, ex_rs2_dat_o, e.rs2d);
                cmp({e.tag, ".imm"},  ex_imm_o,     e.imm);
                cmp({e.tag, ".rs1"},  {27'd0, ex_rs1_o}, {27'd0, e.rs1});
                cmp({e.tag, ".rs2"},  {27'd0, ex_rs2_o}, {27'd0, e.rs2});
                cmp({e.tag, ".rd"},   {27'd0, ex_rd_o},  {27'd0, e.rd});
            end else begin
                n_cmp = n_cmp;
            end
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic rdy,
                         input logic stl, input logic fl);
        id_pc_i    = pc;
        id_inst_i  = inst;
        id_ready_i = rdy;
        ex_stall_i = stl;
        flush_i    = fl;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] dat);
        wb_we_i  = we;
        wb_rd_i  = rd;
        wb_dat_i = dat;
    endtask

    // Queue the expectation, clock once, then check away from the edge.
    task automatic step(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_head();
    endtask

    task automatic chk_stall(input string tag, input logic expv);
        #1;
        cmp(tag, {31'd0, id_stall_o}, {31'd0, expv});
    endtask

    exp_t add_e;

    initial begin
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        wb(1'b0, 5'd0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.push_back(mk("reset", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
                        4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        check_head();
        chk_stall("reset.stall", 1'b0);

        // addi x1,x0,5 (rs2 field reads x5, still zero after reset)
        drive(32'h10, 32'h00500093, 1'b1, 1'b0, 1'b0);
        step(mk("addi", 1'b1, 1'b1, 32'h10, 32'h0, 32'h0, 32'h5, 5'd0, 5'd5, 5'd1,
                4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // add x3,x2,x1 with x1=0x55 written back in the same cycle
        drive(32'h14, 32'h001101B3, 1'b1, 1'b0, 1'b0);
        wb(1'b1, 5'd1, 32'h55);
        step(mk("add_byp", 1'b1, 1'b1, 32'h14, 32'h0, 32'h55, 32'h0, 5'd2, 5'd1, 5'd3,
                4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        wb(1'b0, 5'd0, 32'h0);

        // addi x1,x0,-1 : all-ones immediate
        drive(32'h18, 32'hFFF00093, 1'b1, 1'b0, 1'b0);
        step(mk("addi_neg", 1'b1, 1'b1, 32'h18, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1,
                4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // lw x2,0(x1)
        drive(32'h1C, 32'h0000A103, 1'b1, 1'b0, 1'b0);
        step(mk("lw", 1'b1, 1'b1, 32'h1C, 32'h55, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2,
                4'd0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));

        // add x3,x2,x1 depends on the load: one stall cycle, one bubble
        drive(32'h20, 32'h001101B3, 1'b1, 1'b0, 1'b0);
        chk_stall("hazard.stall_on", 1'b1);
        step(mk_bubble("bubble"));
        chk_stall("hazard.stall_off", 1'b0);
        add_e = mk("add_after", 1'b1, 1'b1, 32'h20, 32'h0, 32'h55, 32'h0, 5'd2, 5'd1, 5'd3,
                   4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(add_e);

        // downstream stall alone: ID/EX holds the add across 3 edges
        drive(32'h24, 32'h123452B7, 1'b1, 1'b1, 1'b0);
        chk_stall("exstall.stall", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(add_e);
        end

        // flush together with stall: flush wins
        drive(32'h24, 32'h123452B7, 1'b1, 1'b1, 1'b1);
        step(mk_bubble("flush"));

        // lui x5,0x12345
        drive(32'h30, 32'h123452B7, 1'b1, 1'b0, 1'b0);
        step(mk("lui", 1'b1, 1'b1, 32'h30, 32'h0, 32'h0, 32'h12345000, 5'd8, 5'd3, 5'd5,
                4'd10, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // undecodable opcode, while a write-back to x0 must be ignored
        drive(32'h34, 32'h0000007F, 1'b1, 1'b0, 1'b0);
        wb(1'b1, 5'd0, 32'hDEADBEEF);
        step(mk("illegal", 1'b1, 1'b1, 32'h34, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
                4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        wb(1'b0, 5'd0, 32'h0);

        // lw x0,0(x1): rd=0 suppresses the register write
        drive(32'h38, 32'h0000A003, 1'b1, 1'b0, 1'b0);
        step(mk("lw_x0", 1'b1, 1'b1, 32'h38, 32'h55, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0,
                4'd0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));

        // add x3,x0,x0 after a load to x0: no hazard
        drive(32'h3C, 32'h000001B3, 1'b1, 1'b0, 1'b0);
        chk_stall("x0load.stall", 1'b0);
        step(mk("add_x0", 1'b1, 1'b1, 32'h3C, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3,
                4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // beq x1,x2,+8 (x0 still reads 0 after the ignored write)
        drive(32'h40, 32'h00208463, 1'b1, 1'b0, 1'b0);
        step(mk("beq", 1'b1, 1'b1, 32'h40, 32'h55, 32'h0, 32'h8, 5'd1, 5'd2, 5'd8,
                4'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));

        drive(32'h44, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction decode stage of the RV32I pipeline.
- Sits directly downstream of the IF/ID register and consumes its instruction, PC and ready outputs.
- Decodes the instruction, reads the 32x32 register file (with write-back bypass) and generates the immediate.
- Registers everything into the ID/EX pipeline register, and detects load-use hazards so that IF is stalled.

Parameters:
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, value loaded into ex_pc_o on reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- id_pc_i  in  32  PC from IF/ID register
- id_inst_i  in  32  instruction from IF/ID register
- id_ready_i  in  1  IF/ID holds a valid instruction
- ex_stall_i  in  1  downstream busy; hold ID/EX contents
- flush_i  in  1  branch/jump redirect; kill the instruction in ID
- wb_we_i  in  1  write-back enable
- wb_rd_i  in  5  write-back destination register
- wb_dat_i  in  32  write-back data
- id_stall_o  in/out: out  1  stall request to IF (load-use hazard or ex_stall_i)
- ex_valid_o  out  1  ID/EX holds a valid instruction
- ex_pc_o  out  32  PC of the EX instruction
- ex_rs1_dat_o, ex_rs2_dat_o  out  32 each  operand values
- ex_imm_o  out  32  sign-extended immediate
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  register indices
- ex_alu_op_o  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- ex_alu_src_o  out  1  1 = operand B is the immediate
- ex_mem_rd_o, ex_mem_wr_o  out  1 each  load / store
- ex_mem_size_o  out  3  funct3 of the load/store
- ex_reg_we_o  out  1  instruction writes rd
- ex_branch_o, ex_jump_o  out  1 each  conditional branch / JAL-JALR
- ex_illegal_o  out  1  undecodable opcode

Behaviour:
- Reset (rst=0, asynchronous):
  - All ex_* outputs are 0, except ex_pc_o = RESET_PC.
  - All 32 register-file entries are cleared to 0.
  - id_stall_o follows its combinational definition below.
- Latency: one cycle. An instruction presented with id_ready_i=1 at edge N appears on ex_* after edge N.
- ID/EX update priority at each rising edge:
  1. flush_i=1 -> ex_valid_o<=0 and all control bits <=0.
  2. ex_stall_i=1 -> hold all ex_* outputs unchanged.
  3. Load-use hazard -> insert a bubble: ex_valid_o<=0, control bits <=0.
  4. Otherwise load the decode result; ex_valid_o<=id_ready_i.
- Load-use hazard (combinational) requires all of the following:
  - id_ready_i, ex_valid_o and ex_mem_rd_o are 1, and ex_rd_o!=0.
  - ex_rd_o matches rs1 of an instruction that uses rs1, or rs2 of one that uses rs2.
  - rs1 is used by every opcode except LUI, AUIPC and JAL; rs2 only by R-type, branch and store.
- id_stall_o = hazard | ex_stall_i. A hazard is asserted for exactly one cycle; afterwards the bubble has cleared ex_mem_rd_o.
- Register file:
  - Write on the rising edge when wb_we_i=1 and wb_rd_i!=0. Writes to x0 are ignored; x0 always reads 0.
  - Same-cycle bypass: if wb_we_i=1, wb_rd_i!=0 and wb_rd_i equals a read index, the read returns wb_dat_i.
  - Write-back is accepted during flush and stall.
- Immediates (always sign-extended from inst[31]):
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
- Decode by opcode:
  - OP / OP-IMM: ALU op from funct3 and funct7[5]. SUB only for OP; SRA for both.
  - LOAD / STORE: ADD with immediate.
  - LUI: PASSB.
  - AUIPC, JAL, JALR: ADD.
  - BRANCH: SUB, ex_branch_o=1.
- ex_reg_we_o=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR, and is forced to 0 when rd=0.
- Unknown opcode: ex_valid_o=1, ex_illegal_o=1, and all write/memory controls are 0.

Test Plan:
- Reset held low 3 cycles, then released -> all ex_* = 0, ex_pc_o = 0, id_stall_o = 0; reading x5 returns 0.
- 0x00500093 (addi x1,x0,5) at pc 0x10 -> next cycle: ex_valid_o=1, ex_rd_o=1, ex_imm_o=5, ex_alu_op_o=0, ex_alu_src_o=1, ex_reg_we_o=1, ex_pc_o=0x10.
- Write-back x1=0x55 in the same cycle that 0x001101B3 (add x3,x2,x1) sits in ID -> ex_rs2_dat_o=0x55 (bypass). 0xFFF00093 -> ex_imm_o=0xFFFFFFFF.
- 0x0000A103 (lw x2,0(x1)) followed by 0x001101B3 -> id_stall_o=1 for exactly one cycle, one bubble (ex_valid_o=0), then the add issues with ex_rs1_o=2.
- flush_i=1 while ex_stall_i=1 with a valid instruction in ID -> ex_valid_o=0 next cycle (flush wins). ex_stall_i=1 alone -> ex_* unchanged across 3 edges.
- 0x123452B7 (lui x5,0x12345) -> ex_imm_o=0x12345000, ex_alu_op_o=10. Opcode 0x7F -> ex_illegal_o=1, ex_reg_we_o=0.
